// File: rtl/timer_pkg.sv
// Shared types and limits for the mm:ss countdown timer.
package timer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SET_SEC = 3'd1,
        SET_MIN = 3'd2,
        PAUSE   = 3'd3,
        RUN     = 3'd4,
        DONE    = 3'd5
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t MAX_SEC_TENS = 4'd5;
    localparam bcd_t MAX_DIGIT    = 4'd9;

    function automatic bcd_t clamp_bcd(input bcd_t d, input bcd_t lim);
        return (d > lim) ? lim : d;
    endfunction

endpackage

// File: rtl/timer_tick_gen.sv
// Countdown prescaler: counts 0..TICK_DIV-1 and pulses tick on the last count.
module timer_tick_gen #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] CNT_MAX = W'(TICK_DIV - 1);
    localparam logic [W-1:0] CNT_ONE = W'(1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count == CNT_MAX) begin
            count <= '0;
        end else begin
            count <= count + CNT_ONE;
        end
    end

    // Gated so a count left over from the final RUN cycle never fires outside RUN.
    assign tick = (count == CNT_MAX) && !clear;

endmodule

// File: rtl/timer_ctrl.sv
// mm:ss countdown timer control FSM with button synchronisers and BCD decrement.
// Optional TIMER_RELOAD_EN: DONE + toggle restarts from the last programmed time.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [7:0]  sw,
    input  logic        key_set_n,
    input  logic        key_toggle_n,
    output logic [15:0] bcd_out,
    output logic        running,
    output logic        done,
    output logic [2:0]  state_out,
    output logic        tick
);

    state_t      state, state_next;
    logic [15:0] digits, digits_next, dec_val;
    logic [2:0]  set_sync, tog_sync;
    logic        set_press, tog_press, tick_clear;
    logic [7:0]  sw_sec, sw_min;
`ifdef TIMER_RELOAD_EN
    logic [15:0] reload, reload_next;
`endif

    // [0],[1] synchronise; [2] holds the previous synchronised level for edge detect.
    assign set_press = set_sync[2] & ~set_sync[1];
    assign tog_press = tog_sync[2] & ~tog_sync[1];

    assign sw_sec = {clamp_bcd(sw[7:4], MAX_SEC_TENS), clamp_bcd(sw[3:0], MAX_DIGIT)};
    assign sw_min = {clamp_bcd(sw[7:4], MAX_DIGIT),    clamp_bcd(sw[3:0], MAX_DIGIT)};

    assign tick_clear = (state != RUN);

    timer_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (CLOCK_50),
        .reset(reset),
        .clear(tick_clear),
        .tick (tick)
    );

    always_comb begin
        dec_val = digits;
        if (digits[3:0] != 4'd0) begin
            dec_val[3:0] = digits[3:0] - 4'd1;
        end else begin
            dec_val[3:0] = MAX_DIGIT;
            if (digits[7:4] != 4'd0) begin
                dec_val[7:4] = digits[7:4] - 4'd1;
            end else begin
                dec_val[7:4] = MAX_SEC_TENS;
                if (digits[11:8] != 4'd0) begin
                    dec_val[11:8] = digits[11:8] - 4'd1;
                end else begin
                    dec_val[11:8]  = MAX_DIGIT;
                    dec_val[15:12] = digits[15:12] - 4'd1;
                end
            end
        end
    end

    always_comb begin
        state_next  = state;
        digits_next = digits;
`ifdef TIMER_RELOAD_EN
        reload_next = reload;
`endif
        case (state)
            IDLE: begin
                if (set_press) begin
                    state_next  = SET_SEC;
                    digits_next = '0;
                end
            end
            SET_SEC: begin
                if (set_press) begin
                    digits_next[7:0] = sw_sec;
                    state_next       = SET_MIN;
                end
            end
            SET_MIN: begin
                if (set_press) begin
                    digits_next[15:8] = sw_min;
                    state_next        = PAUSE;
`ifdef TIMER_RELOAD_EN
                    reload_next = {sw_min, digits[7:0]};
`endif
                end
            end
            PAUSE: begin
                if (tog_press) begin
                    state_next = (digits == '0) ? DONE : RUN;
                end else if (set_press) begin
                    state_next = SET_SEC;
                end
            end
            RUN: begin
                if (tick) begin
                    digits_next = dec_val;
                    if (dec_val == '0) begin
                        state_next = DONE;
                    end else if (tog_press) begin
                        state_next = PAUSE;
                    end
                end else if (tog_press) begin
                    state_next = PAUSE;
                end
            end
            DONE: begin
                if (tog_press) begin
`ifdef TIMER_RELOAD_EN
                    // A zero reload has nothing to count, so it behaves like set.
                    if (reload != '0) begin
                        digits_next = reload;
                        state_next  = RUN;
                    end else begin
                        digits_next = '0;
                        state_next  = IDLE;
                    end
`else
                    digits_next = '0;
                    state_next  = IDLE;
`endif
                end else if (set_press) begin
                    digits_next = '0;
                    state_next  = IDLE;
                end
            end
            default: begin
                digits_next = '0;
                state_next  = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state    <= IDLE;
            digits   <= '0;
            set_sync <= '1;
            tog_sync <= '1;
`ifdef TIMER_RELOAD_EN
            reload   <= '0;
`endif
        end else begin
            state    <= state_next;
            digits   <= digits_next;
            set_sync <= {set_sync[1:0], key_set_n};
            tog_sync <= {tog_sync[1:0], key_toggle_n};
`ifdef TIMER_RELOAD_EN
            reload   <= reload_next;
`endif
        end
    end

    always_comb begin
        case (state)
            IDLE, DONE: bcd_out = '0;
            SET_SEC:    bcd_out = {digits[15:8], sw_sec};
            SET_MIN:    bcd_out = {sw_min, digits[7:0]};
            default:    bcd_out = digits;
        endcase
    end

    assign running   = (state == RUN);
    assign done      = (state == DONE);
    assign state_out = state;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl with TICK_DIV=4.
module tb_timer_ctrl;

    logic        CLOCK_50;
    logic        reset;
    logic [7:0]  sw;
    logic        key_set_n;
    logic        key_toggle_n;
    logic [15:0] bcd_out;
    logic        running;
    logic        done;
    logic [2:0]  state_out;
    logic        tick;

    int checks = 0;
    int errors = 0;

    timer_ctrl #(
        .TICK_DIV(4)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .sw          (sw),
        .key_set_n   (key_set_n),
        .key_toggle_n(key_toggle_n),
        .bcd_out     (bcd_out),
        .running     (running),
        .done        (done),
        .state_out   (state_out),
        .tick        (tick)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic cyc(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns one cycle after the FSM has acted on the press (3rd edge after the fall).
    task automatic press(input logic s, input logic t);
        key_set_n    = ~s;
        key_toggle_n = ~t;
        cyc(3);
        key_set_n    = 1'b1;
        key_toggle_n = 1'b1;
        cyc(1);
    endtask

    task automatic program_time(input logic [7:0] sec_sw, input logic [7:0] min_sw);
        press(1'b1, 1'b0);
        sw = sec_sw;
        press(1'b1, 1'b0);
        sw = min_sw;
        press(1'b1, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(1);
    endtask

    initial begin
        reset        = 1'b1;
        sw           = 8'h00;
        key_set_n    = 1'b1;
        key_toggle_n = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(1);
        check("rst_state",   16'(state_out), 16'd0);
        check("rst_bcd",     bcd_out,        16'h0000);
        check("rst_running", 16'(running),   16'd0);
        check("rst_done",    16'(done),      16'd0);
        check("rst_tick",    16'(tick),      16'd0);

        // Program 01:25 and run
        press(1'b1, 1'b0);
        check("set_sec_state", 16'(state_out), 16'd1);
        sw = 8'h25; #1;
        check("set_sec_live", bcd_out, 16'h0025);
        press(1'b1, 1'b0);
        check("set_min_state", 16'(state_out), 16'd2);
        sw = 8'h01; #1;
        check("set_min_live", bcd_out, 16'h0125);
        press(1'b1, 1'b0);
        check("pause_state", 16'(state_out), 16'd3);
        check("pause_bcd",   bcd_out,        16'h0125);
        press(1'b0, 1'b1);
        check("run_running", 16'(running), 16'd1);
        check("run_bcd0",    bcd_out,      16'h0125);
        cyc(2);
        check("run_tick",    16'(tick),    16'd1);
        check("run_bcd_pre", bcd_out,      16'h0125);
        cyc(1);
        check("run_dec1",    bcd_out,      16'h0124);
        check("run_tick_lo", 16'(tick),    16'd0);
        press(1'b0, 1'b1);
        check("pause2_state", 16'(state_out), 16'd3);
        check("pause2_bcd",   bcd_out,        16'h0124);

        // 01:00 borrow path and expiry
        do_reset();
        program_time(8'h00, 8'h01);
        check("p100_bcd", bcd_out, 16'h0100);
        press(1'b0, 1'b1);
        cyc(3);
        check("borrow_0059", bcd_out, 16'h0059);
        cyc(232);
        check("near_0001",    bcd_out,      16'h0001);
        check("near_running", 16'(running), 16'd1);
        cyc(4);
        check("exp_bcd",     bcd_out,        16'h0000);
        check("exp_done",    16'(done),      16'd1);
        check("exp_running", 16'(running),   16'd0);
        check("exp_state",   16'(state_out), 16'd5);
        press(1'b1, 1'b0);
        check("done_set_idle", 16'(state_out), 16'd0);

        // Clamping and PAUSE -> SET_SEC keeping digits
        press(1'b1, 1'b0);
        sw = 8'hFF; #1;
        check("clamp_sec_live", bcd_out, 16'h0059);
        press(1'b1, 1'b0);
        sw = 8'hA3; #1;
        check("clamp_min_live", bcd_out, 16'h9359);
        sw = 8'hFF; #1;
        press(1'b1, 1'b0);
        check("clamp_9959",  bcd_out,        16'h9959);
        check("clamp_state", 16'(state_out), 16'd3);
        press(1'b1, 1'b0);
        check("reset_sec_state", 16'(state_out), 16'd1);
        sw = 8'h00; #1;
        check("digits_kept", bcd_out, 16'h9900);

        // 10:00 -> 09:59 borrows through minute ones
        do_reset();
        program_time(8'h00, 8'h10);
        press(1'b0, 1'b1);
        cyc(3);
        check("borrow_0959", bcd_out, 16'h0959);

        // 99:59 over 60 ticks
        do_reset();
        program_time(8'hFF, 8'hFF);
        press(1'b0, 1'b1);
        cyc(3);
        check("run_9958", bcd_out, 16'h9958);
        cyc(236);
        check("run_9859", bcd_out, 16'h9859);

        // Toggle coinciding with a tick: decrement then PAUSE; paused hold; resume latency
        do_reset();
        program_time(8'h06, 8'h00);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        check("tick_tog_state", 16'(state_out), 16'd3);
        check("tick_tog_bcd",   bcd_out,        16'h0005);
        cyc(20);
        check("hold_bcd",  bcd_out,   16'h0005);
        check("hold_tick", 16'(tick), 16'd0);
        press(1'b0, 1'b1);
        check("resume_running", 16'(running), 16'd1);
        cyc(2);
        check("resume_pre", bcd_out, 16'h0005);
        cyc(1);
        check("resume_dec", bcd_out, 16'h0004);

        // Set ignored in RUN; simultaneous presses in RUN; reset in RUN
        press(1'b1, 1'b0);
        check("run_set_ign", 16'(state_out), 16'd4);
        check("run_set_bcd", bcd_out,        16'h0003);
        press(1'b1, 1'b1);
        check("both_state", 16'(state_out), 16'd3);
        check("both_bcd",   bcd_out,        16'h0003);
        press(1'b0, 1'b1);
        cyc(1);
        reset = 1'b1;
        cyc(1);
        check("mid_rst_state",   16'(state_out), 16'd0);
        check("mid_rst_bcd",     bcd_out,        16'h0000);
        check("mid_rst_running", 16'(running),   16'd0);
        reset = 1'b0;
        cyc(1);

        // PAUSE at 00:00 goes straight to DONE
        program_time(8'h00, 8'h00);
        press(1'b0, 1'b1);
        check("zero_done_state", 16'(state_out), 16'd5);
        check("zero_done_flag",  16'(done),      16'd1);
        press(1'b1, 1'b0);
        check("zero_done_idle", 16'(state_out), 16'd0);

        // DONE + toggle
        program_time(8'h01, 8'h00);
        press(1'b0, 1'b1);
        cyc(3);
        check("d01_done", 16'(done), 16'd1);
        press(1'b0, 1'b1);
`ifdef TIMER_RELOAD_EN
        check("reload_state", 16'(state_out), 16'd4);
        check("reload_bcd",   bcd_out,        16'h0001);
        cyc(3);
        check("reload_done", 16'(state_out), 16'd5);
        press(1'b1, 1'b0);
        check("reload_set_idle", 16'(state_out), 16'd0);
`else
        check("done_tog_state", 16'(state_out), 16'd0);
        check("done_tog_bcd",   bcd_out,        16'h0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
